// File: rtl/fpmult_round_pack_stage.sv
// ---------------------------------------------------------------------------
// fpmult_round_pack_stage
//
// Final stage of the single-precision multiplier. Takes the normalized
// exponent pair (E, E+1) and mantissa pair (M, M+1) from the normalize
// stage and applies round-to-nearest-even. It then packs an IEEE-754 single
// and holds the result in a 2-entry skid buffer. Exception flags are
// accumulated for the FPU status logic.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid        upstream result valid
//   in_ready        stage can accept (registered, low only when both entries full)
//   RoundE/RoundEP  biased exponent, and the exponent used when rounding carries
//   RoundM/RoundMP  unrounded mantissa and mantissa+1 (bit 23 = carry-out)
//   Sgn             result sign
//   Guard, Sticky   rounding bits below the LSB
//   Unf             exponent underflow detected upstream
//   NanIn/InfIn/ZeroIn  special-case results
//   out_valid       Z valid
//   out_ready       downstream accepts
//   Z               packed single-precision result
//   Flags           {invalid, overflow, underflow, inexact, carry_round} for Z
//   StickyFlags     OR of Flags of every transferred result
//   flag_clr        clear StickyFlags
// ---------------------------------------------------------------------------
module fpmult_round_pack_stage #(
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        RoundE,
    input  logic [8:0]        RoundEP,
    input  logic [23:0]       RoundM,
    input  logic [23:0]       RoundMP,
    input  logic              Sgn,
    input  logic              Guard,
    input  logic              Sticky,
    input  logic              Unf,
    input  logic              NanIn,
    input  logic              InfIn,
    input  logic              ZeroIn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       Z,
    output logic [FLAG_W-1:0] Flags,
    output logic [FLAG_W-1:0] StickyFlags,
    input  logic              flag_clr
);

    localparam int FL_INVALID = 4;
    localparam int FL_OVERFLOW = 3;
    localparam int FL_UNDERFLOW = 2;
    localparam int FL_INEXACT = 1;
    localparam int FL_CARRY = 0;

    // ------------------------------------------------------------------
    // Round and pack (combinational)
    // ------------------------------------------------------------------
    logic              rup;
    logic              carry;
    logic              inexact;
    logic [22:0]       sel_m;
    logic [8:0]        sel_e;
    logic [31:0]       res_z;
    logic [FLAG_W-1:0] res_flags;

    // RoundM[23] is always zero by construction upstream.
    logic unused_round_m_msb;
    assign unused_round_m_msb = RoundM[23];

    always_comb begin
        // Round up when above half, or exactly half with an odd LSB (ties to even).
        rup     = Guard & (Sticky | RoundM[0]);
        carry   = rup & RoundMP[23];
        inexact = Guard | Sticky;

        sel_m = RoundM[22:0];
        sel_e = RoundE;
        if (rup) begin
            if (carry) begin
                // M+1 overflowed into bit 23: mantissa wraps to 1.0, exponent +1.
                sel_m = '0;
                sel_e = RoundEP;
            end else begin
                sel_m = RoundMP[22:0];
            end
        end

        res_z     = '0;
        res_flags = '0;
        if (NanIn) begin
            res_z                 = 32'h7FC0_0000;
            res_flags[FL_INVALID] = 1'b1;
        end else if (InfIn) begin
            res_z = {Sgn, 8'hFF, 23'd0};
        end else if (ZeroIn) begin
            res_z = {Sgn, 31'd0};
        end else begin
            res_flags[FL_INEXACT] = inexact;
            res_flags[FL_CARRY]   = carry;
            if (Unf || (sel_e == 9'd0)) begin
                // No denormal support: flush to signed zero.
                res_z                   = {Sgn, 31'd0};
                res_flags[FL_UNDERFLOW] = 1'b1;
                res_flags[FL_INEXACT]   = 1'b1;
            end else if (sel_e >= 9'd255) begin
                res_z                  = {Sgn, 8'hFF, 23'd0};
                res_flags[FL_OVERFLOW] = 1'b1;
                res_flags[FL_INEXACT]  = 1'b1;
            end else begin
                res_z = {Sgn, sel_e[7:0], sel_m};
            end
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer and sticky flags
    //
    // Handshake: a beat moves on a rising edge where valid & ready are both
    // high on that side. in_valid/in_ready: upstream beat accepted.
    // out_valid/out_ready: Z/Flags transferred. While out_valid is high and
    // out_ready is low, Z and Flags hold. R0 is the visible entry; R1 only
    // fills when R0 is stalled, and in_ready is simply !R1-full.
    // ------------------------------------------------------------------
    logic              r0_valid_q, r0_valid_d;
    logic [31:0]       r0_z_q, r0_z_d;
    logic [FLAG_W-1:0] r0_flags_q, r0_flags_d;
    logic              r1_valid_q, r1_valid_d;
    logic [31:0]       r1_z_q, r1_z_d;
    logic [FLAG_W-1:0] r1_flags_q, r1_flags_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic              accept;
    logic              xfer;

    assign in_ready    = ~r1_valid_q;
    assign out_valid   = r0_valid_q;
    assign Z           = r0_z_q;
    assign Flags       = r0_flags_q;
    assign StickyFlags = sticky_q;

    always_comb begin
        accept = in_valid & in_ready;
        xfer   = r0_valid_q & out_ready;

        r0_valid_d = r0_valid_q;
        r0_z_d     = r0_z_q;
        r0_flags_d = r0_flags_q;
        r1_valid_d = r1_valid_q;
        r1_z_d     = r1_z_q;
        r1_flags_d = r1_flags_q;

        if (xfer) begin
            if (r1_valid_q) begin
                r0_z_d     = r1_z_q;
                r0_flags_d = r1_flags_q;
                r1_valid_d = 1'b0;
            end else begin
                r0_valid_d = 1'b0;
            end
        end

        // accept implies R1 empty, so R1 never has to drain and fill at once.
        if (accept) begin
            if (!r0_valid_q || xfer) begin
                r0_valid_d = 1'b1;
                r0_z_d     = res_z;
                r0_flags_d = res_flags;
            end else begin
                r1_valid_d = 1'b1;
                r1_z_d     = res_z;
                r1_flags_d = res_flags;
            end
        end

        // Clear and set together: the newly transferred flags survive.
        if (flag_clr) begin
            sticky_d = xfer ? r0_flags_q : '0;
        end else begin
            sticky_d = sticky_q | (xfer ? r0_flags_q : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid_q <= 1'b0;
            r0_z_q     <= '0;
            r0_flags_q <= '0;
            r1_valid_q <= 1'b0;
            r1_z_q     <= '0;
            r1_flags_q <= '0;
            sticky_q   <= '0;
        end else begin
            r0_valid_q <= r0_valid_d;
            r0_z_q     <= r0_z_d;
            r0_flags_q <= r0_flags_d;
            r1_valid_q <= r1_valid_d;
            r1_z_q     <= r1_z_d;
            r1_flags_q <= r1_flags_d;
            sticky_q   <= sticky_d;
        end
    end

endmodule

// File: doc/fpmult_round_pack_stage.md
Name: fpmult_round_pack_stage

Overview:
- Pipeline stage directly downstream of the multiplier normalize stage.
- Consumes the precomputed exponent pair (E, E+1) and mantissa pair (M, M+1), the sign, the guard/sticky bits and the special-case flags.
- Selects round-to-nearest-even, packs an IEEE-754 single, and registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Accumulates sticky exception flags for the FPU status logic.

Parameters:
- FLAG_W, 5, width of the exception flag vector {invalid, overflow, underflow, inexact, carry_round}.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept; registered, equals !skid_full.
- RoundE  in  9  biased result exponent (NormE-127).
- RoundEP  in  9  biased exponent for the mantissa-carry case (NormE-126).
- RoundM  in  24  unrounded mantissa; bit 23 always 0.
- RoundMP  in  24  RoundM+1; bit 23 is the carry-out.
- Sgn  in  1  result sign.
- Guard  in  1  first bit below the LSB.
- Sticky  in  1  OR of all bits below Guard.
- Unf  in  1  NormE<127; exponent underflow, precomputed upstream.
- NanIn  in  1  special case: NaN result.
- InfIn  in  1  special case: infinite result.
- ZeroIn  in  1  special case: zero result.
- out_valid  out  1  Z valid.
- out_ready  in  1  downstream accepts.
- Z  out  32  packed single-precision result.
- Flags  out  FLAG_W  per-result flags, aligned with Z.
- StickyFlags  out  FLAG_W  accumulated flags.
- flag_clr  in  1  clear StickyFlags.

Behaviour:
- Reset values: out_valid=0, in_ready=1, Z=0, Flags=0, StickyFlags=0, skid empty.
- Reset mid-operation discards both entries. No output beat appears after reset until a new input is accepted.
- Accept when in_valid & in_ready. Latency: accept at edge n → Z valid after edge n (one register).
- Round decision: rup = Guard & (Sticky | RoundM[0]).
  - Ties go to even.
  - Inexact = Guard | Sticky.
- Mantissa/exponent select:
  - rup=0: M=RoundM, E=RoundE.
  - rup=1 and RoundMP[23]=0: M=RoundMP, E=RoundE.
  - rup=1 and RoundMP[23]=1: M=0, E=RoundEP.
- Classification, priority highest first:
  1. NanIn → Z=0x7FC00000, invalid=1.
  2. InfIn → Z={Sgn,0xFF,0}.
  3. ZeroIn → Z={Sgn,0x00,0}.
  4. Unf, or selected E==0 → Z={Sgn,0}, underflow=1, inexact=1. No denormals; flush to zero.
  5. Selected E≥255 (9-bit unsigned) → Z={Sgn,0xFF,0}, overflow=1, inexact=1.
  6. Otherwise → Z={Sgn,E[7:0],M[22:0]}.
- Flags bits: [4] invalid, [3] overflow, [2] underflow, [1] inexact, [0] carry_round (rup & RoundMP[23]).
  - Special cases (NaN/Inf/Zero in) force inexact=0 and carry_round=0.
- StickyFlags:
  - ORs in Flags of each result on the cycle it is transferred out (out_valid & out_ready).
  - flag_clr zeroes it.
  - Simultaneous clr and transfer: result = transferred Flags; set wins over the old value.
- Skid buffer: main register R0 drives Z/Flags; skid register R1 is hidden.
  - Accept with R0 empty, or R0 draining (out_ready=1): result goes to R0.
  - Accept while R0 full and out_ready=0: result goes to R1; in_ready falls the next cycle.
  - Transfer out with R1 full: R1 moves to R0; in_ready rises the next cycle.
  - Order strictly preserved. No beat dropped or duplicated. Z/Flags stable while out_valid & !out_ready.
- Full/empty: at most 2 results held; in_ready=0 only when both entries are full.
- Simultaneous accept and transfer when full is impossible, since in_ready=0.
- Simultaneous accept and transfer with only R0 full: new result goes to R0 directly; R1 stays empty.

Test Plan:
- Exact: RoundE=0x07F, RoundM=0x400000, G=S=0, Sgn=0 → Z=0x3FC00000, Flags=0, out_valid one cycle after accept.
- Ties-to-even:
  - RoundM=0x000002, RoundMP=0x000003, G=1, S=0 → Z=0x3F800002, inexact.
  - RoundM=0x000003, RoundMP=0x000004 → Z=0x3F800004.
- Carry: RoundM=0x7FFFFF, RoundMP=0x800000, RoundE=0x07F, RoundEP=0x080, G=1, S=1 → Z=0x40000000, Flags=0x03.
- Overflow/underflow:
  - RoundE=0x0FF, Sgn=1 → Z=0xFF800000, Flags=0x0A.
  - Unf=1, Sgn=0 → Z=0x00000000, Flags=0x06.
  - NanIn=1 with InfIn=1 → Z=0x7FC00000, Flags=0x10.
- Backpressure: hold out_ready=0 and offer 3 back-to-back inputs A,B,C → A,B accepted, in_ready=0 from the cycle after B. Release out_ready → Z=A, B, C in order. No loss.
- StickyFlags: overflow result transferred with flag_clr=1 on the same cycle → StickyFlags=0x0A. Reset asserted with 2 entries held → out_valid=0 and in_ready=1 the next cycle.
